des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Sequential DES key schedule. Loads a 64-bit key and emits the sixteen 48-bit round subkeys one at a time, in encryption order (K1..K16) or decryption order (K16..K1), over a valid/ready handshake. Each subkey feeds the round's E-expansion/XOR stage, which drives the eight 6-bit S-box lookups S1..S8. Three instances serve the 3DES core.

## Interface
- No parameters; all DES tables are fixed constants.
- `clk`  in  1  single clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_in`  in  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,…,64 ignored.
- `decrypt`  in  1  sampled with `start`; 1 = emit K16 first.
- `start`  in  1  single-cycle load request; honoured only when `busy`=0.
- `subkey`  out  [1:48]  PC-2 of current C/D registers.
- `subkey_valid`  out  1  `subkey` holds round `round_idx`'s key.
- `subkey_ready`  in  1  consumer accepts `subkey` when high with `subkey_valid`.
- `round_idx`  out  [4:0]  logical round number 1..16 (decrypt counts 16 down to 1); 0 when idle.
- `busy`  out  1  high from the cycle after an accepted `start` until after the 16th acceptance.
- `done`  out  1  one-cycle pulse the cycle after the 16th handshake.

## Operation
- State machine: IDLE, EMIT.
- IDLE: `busy`=0, `subkey_valid`=0. On `start`=1:
  - C/D ← PC-1(`key_in`), then left rotate 1 if encrypting, no rotate if decrypting.
  - Latch `decrypt` into `dir`.
  - Step counter ← 1; go to EMIT.
- EMIT: `subkey_valid`=1. On handshake (`subkey_valid` & `subkey_ready`):
  - Step 16: go to IDLE, clear C/D and step counter to 0, pulse `done`.
  - Otherwise increment the step and rotate C and D (each 28 bits, independently) by the next step's amount.
  - Encrypt: left rotate; schedule by step 1..16 = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt: right rotate; schedule by step 1..16 = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- `round_idx` = step when encrypting, 17−step when decrypting, 0 in IDLE.
- No handshake: C/D, step and `subkey` hold indefinitely (stall).
- `start` while `busy`=1 is ignored; `dir` does not change mid-sequence.
- `start` in the same cycle as the 16th handshake is ignored, because `busy` is still 1. The earliest reload is the `done` cycle.
- `decrypt` and `key_in` matter only in the `start` cycle.

## Timing
- Reset (async assert, sync release) sets:
  - state IDLE, C/D = 0, step = 0, `dir` = 0.
  - Outputs: `subkey`=0, `subkey_valid`=0, `busy`=0, `round_idx`=0, `done`=0.
- `start` in cycle N gives `subkey_valid`=1 and round-1 key in N+1.
- Handshake in cycle M gives the next key in M+1 (one key per cycle at full throughput).
- Minimum sequence: 17 cycles from `start` to `done`.
- `subkey` is pure wiring from registers; no combinational path from any input to any output.
- Reset mid-sequence aborts immediately. No `done` pulse is issued for the aborted sequence.

## Structure
- `des_pkg` holds:
  - PC-1 and PC-2 permutations as functions.
  - The 16-entry encrypt and decrypt rotate schedules as constants.
  - The state encoding and the 28-bit rotate functions.
- `des_pkg` is shared with the round/S-box datapath.
- One sub-module: `des_pc2`, combinational 56→48 permutation, instanced once on the C/D registers.

## Test plan
- Encrypt, key 0x133457799BBCDFF1, `subkey_ready`=1:
  - K1=0x1B02EFFC7072, K2=0x79AED9DBC9E5, K16=0xCB3D8B0E17F5.
  - `round_idx` 1..16, `done` in cycle N+17.
- Same key with `decrypt`=1: first key 0xCB3D8B0E17F5 with `round_idx`=16, last key 0x1B02EFFC7072 with `round_idx`=1.
- Parity independence: key 0x123457799BBCDFF0 (parity bits changed) → key sequence identical to the first test.
- Backpressure: hold `subkey_ready`=0 for 5 cycles at round 3 → `subkey` and `round_idx`=3 stable; the sequence resumes with no loss or duplication.
- Pulse `start` with another key at round 7 → ignored; remaining keys still from the original key.
- `start` coincident with the 16th handshake → ignored. `start` on the `done` cycle → new key K1 the next cycle.
- Assert `rst` at round 9 → all outputs 0 asynchronously; no `done` pulse.

Source files
------------

// File: rtl/des_pkg.sv
// DES key-schedule constants and helpers: PC-1/PC-2 permutations, rotate schedules,
// 28-bit half rotations and the key-schedule state encoding. Shared with the round datapath.
package des_pkg;

    localparam int unsigned KEY_W    = 64;
    localparam int unsigned CD_W     = 56;
    localparam int unsigned HALF_W   = 28;
    localparam int unsigned SUBKEY_W = 48;
    localparam int unsigned STEP_W   = 5;
    localparam int unsigned ROUNDS   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Entry i is the rotate amount applied when entering step i+1.
    localparam logic [1:0] ENC_SHIFT [ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };
    localparam logic [1:0] DEC_SHIFT [ROUNDS] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [1:0] shift_amt(input logic dir, input logic [3:0] idx);
        return dir ? DEC_SHIFT[idx] : ENC_SHIFT[idx];
    endfunction

    // Left rotate for encryption, right rotate for decryption.
    function automatic logic [1:HALF_W] rot28(input logic [1:HALF_W] x, input logic right,
                                              input logic [1:0] n);
        logic [1:HALF_W] r;
        r = x;
        case ({right, n})
            3'b001:  r = {x[2:28], x[1]};
            3'b010:  r = {x[3:28], x[1:2]};
            3'b101:  r = {x[28], x[1:27]};
            3'b110:  r = {x[27:28], x[1:26]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [1:CD_W] pc1(input logic [1:KEY_W] k);
        return {k[57], k[49], k[41], k[33], k[25], k[17], k[9],
                k[1],  k[58], k[50], k[42], k[34], k[26], k[18],
                k[10], k[2],  k[59], k[51], k[43], k[35], k[27],
                k[19], k[11], k[3],  k[60], k[52], k[44], k[36],
                k[63], k[55], k[47], k[39], k[31], k[23], k[15],
                k[7],  k[62], k[54], k[46], k[38], k[30], k[22],
                k[14], k[6],  k[61], k[53], k[45], k[37], k[29],
                k[21], k[13], k[5],  k[28], k[20], k[12], k[4]};
    endfunction

    function automatic logic [1:SUBKEY_W] pc2(input logic [1:CD_W] cd);
        return {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
                cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
                cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
                cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
                cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
                cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
                cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
                cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key load request and subkey valid/ready stream of the DES key schedule.
interface des_key_schedule_if;
    import des_pkg::*;

    logic [1:KEY_W]      key_in;
    logic                decrypt;
    logic                start;
    logic [1:SUBKEY_W]   subkey;
    logic                subkey_valid;
    logic                subkey_ready;
    logic [STEP_W-1:0]   round_idx;
    logic                busy;
    logic                done;

    modport master (
        output key_in, decrypt, start, subkey_ready,
        input  subkey, subkey_valid, round_idx, busy, done
    );

    modport slave (
        input  key_in, decrypt, start, subkey_ready,
        output subkey, subkey_valid, round_idx, busy, done
    );

endinterface

// File: rtl/des_pc2.sv
// Combinational PC-2 compression of the concatenated C/D registers into a round subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [1:CD_W]     cd,
    output logic [1:SUBKEY_W] subkey
);

    assign subkey = pc2(cd);

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: loads a key and streams K1..K16 (or K16..K1) over valid/ready.
module des_key_schedule
    import des_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    des_key_schedule_if.slave     bus
);

    state_t              state_q;
    state_t              state_d;
    logic [1:HALF_W]     c_q;
    logic [1:HALF_W]     d_q;
    logic [STEP_W-1:0]   step_q;
    logic                dir_q;
    logic                done_q;

    logic [1:CD_W]       pc1_key;
    logic [1:0]          load_amt;
    logic [1:0]          step_amt;
    logic [1:SUBKEY_W]   subkey_w;
    logic                hs;
    logic                last;

    assign pc1_key  = pc1(bus.key_in);
    assign load_amt = shift_amt(bus.decrypt, 4'd0);
    assign step_amt = shift_amt(dir_q, step_q[3:0]);
    assign hs       = (state_q == ST_EMIT) && bus.subkey_ready;
    assign last     = (step_q == STEP_W'(ROUNDS));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start)  state_d = ST_EMIT;
            ST_EMIT: if (hs && last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and step registers only
    always_comb begin
        bus.subkey_valid = 1'b0;
        bus.busy         = 1'b0;
        bus.round_idx    = '0;
        if (state_q == ST_EMIT) begin
            bus.subkey_valid = 1'b1;
            bus.busy         = 1'b1;
            bus.round_idx    = dir_q ? STEP_W'(STEP_W'(ROUNDS + 1) - step_q) : step_q;
        end
    end

    // C/D halves, step counter, direction and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q    <= '0;
            d_q    <= '0;
            step_q <= '0;
            dir_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == ST_IDLE) && bus.start) begin
                c_q    <= rot28(pc1_key[1:28], 1'b0, load_amt);
                d_q    <= rot28(pc1_key[29:56], 1'b0, load_amt);
                dir_q  <= bus.decrypt;
                step_q <= STEP_W'(1);
            end else if (hs) begin
                if (last) begin
                    c_q    <= '0;
                    d_q    <= '0;
                    step_q <= '0;
                    done_q <= 1'b1;
                end else begin
                    c_q    <= rot28(c_q, dir_q, step_amt);
                    d_q    <= rot28(d_q, dir_q, step_amt);
                    step_q <= step_q + STEP_W'(1);
                end
            end
        end
    end

    des_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (subkey_w)
    );

    assign bus.subkey = subkey_w;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: table of full key sequences plus stall/start/reset corners.
module tb_des_key_schedule;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    des_key_schedule_if bus ();

    des_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] key;
        logic        dec;
        logic        zero;
    } vec_t;

    localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_PAR = 64'h123457799BBCDFF0;

    logic [47:0] kexp [1:16];
    vec_t        vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the key presented at logical step s of a sequence.
    task automatic exp_key(input int s, input logic dec, input logic zero, input string tag);
        int          idx;
        logic [47:0] k;
        idx = dec ? 17 - s : s;
        k   = zero ? 48'h0 : kexp[idx];
        chk($sformatf("%s s%0d valid", tag, s), 64'(bus.subkey_valid), 64'd1);
        chk($sformatf("%s s%0d subkey", tag, s), 64'(bus.subkey), 64'(k));
        chk($sformatf("%s s%0d round_idx", tag, s), 64'(bus.round_idx), 64'(idx));
        chk($sformatf("%s s%0d done", tag, s), 64'(bus.done), 64'd0);
    endtask

    task automatic start_seq(input logic [63:0] key, input logic dec);
        bus.key_in  = key;
        bus.decrypt = dec;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.key_in  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.decrypt = ~dec;
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, " done"}, 64'(bus.done), 64'(exp_done));
        chk({tag, " busy"}, 64'(bus.busy), 64'd0);
        chk({tag, " valid"}, 64'(bus.subkey_valid), 64'd0);
        chk({tag, " round_idx"}, 64'(bus.round_idx), 64'd0);
        chk({tag, " subkey"}, 64'(bus.subkey), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string tag;
        tag = $sformatf("vec%0d", n);
        start_seq(v.key, v.dec);
        for (int s = 1; s <= 16; s++) begin
            exp_key(s, v.dec, v.zero, tag);
            tick();
        end
        chk_idle({tag, " end"}, 1'b1);
        tick();
        chk({tag, " done pulse width"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        kexp[1]  = 48'h1B02EFFC7072; kexp[2]  = 48'h79AED9DBC9E5;
        kexp[3]  = 48'h55FC8A42CF99; kexp[4]  = 48'h72ADD6DB351D;
        kexp[5]  = 48'h7CEC07EB53A8; kexp[6]  = 48'h63A53E507B2F;
        kexp[7]  = 48'hEC84B7F618BC; kexp[8]  = 48'hF78A3AC13BFB;
        kexp[9]  = 48'hE0DBEBEDE781; kexp[10] = 48'hB1F347BA464F;
        kexp[11] = 48'h215FD3DED386; kexp[12] = 48'h7571F59467E9;
        kexp[13] = 48'h97C5D1FABA41; kexp[14] = 48'h5F43B7F2E73A;
        kexp[15] = 48'hBF918D3D3F0A; kexp[16] = 48'hCB3D8B0E17F5;

        vecs[0] = '{key: KEY_A,   dec: 1'b0, zero: 1'b0};
        vecs[1] = '{key: KEY_A,   dec: 1'b1, zero: 1'b0};
        vecs[2] = '{key: KEY_PAR, dec: 1'b0, zero: 1'b0};
        vecs[3] = '{key: KEY_PAR, dec: 1'b1, zero: 1'b0};
        vecs[4] = '{key: 64'h0101010101010101, dec: 1'b0, zero: 1'b1};

        bus.key_in       = '0;
        bus.decrypt      = 1'b0;
        bus.start        = 1'b0;
        bus.subkey_ready = 1'b1;

        #1 rst = 1'b1;
        #2;
        chk_idle("reset", 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk_idle("post reset", 1'b0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Backpressure at round 3
        start_seq(KEY_A, 1'b0);
        for (int s = 1; s <= 16; s++) begin
            if (s == 3) begin
                bus.subkey_ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    exp_key(3, 1'b0, 1'b0, "stall");
                    chk($sformatf("stall%0d busy", j), 64'(bus.busy), 64'd1);
                    tick();
                end
                bus.subkey_ready = 1'b1;
            end
            exp_key(s, 1'b0, 1'b0, "bp");
            tick();
        end
        chk_idle("bp end", 1'b1);
        tick();

        // start with a different key at round 7 must be ignored
        start_seq(KEY_A, 1'b0);
        for (int s = 1; s <= 16; s++) begin
            exp_key(s, 1'b0, 1'b0, "midstart");
            if (s == 7) begin
                bus.key_in  = 64'h0;
                bus.decrypt = 1'b1;
                bus.start   = 1'b1;
            end
            tick();
            bus.start = 1'b0;
        end
        chk_idle("midstart end", 1'b1);
        tick();

        // start with 16th handshake ignored; start in done cycle accepted; reset at round 9
        start_seq(KEY_A, 1'b0);
        for (int s = 1; s <= 16; s++) begin
            exp_key(s, 1'b0, 1'b0, "coinc");
            if (s == 16) begin
                bus.key_in  = KEY_A;
                bus.decrypt = 1'b1;
                bus.start   = 1'b1;
            end
            tick();
        end
        chk_idle("coinc done cycle", 1'b1);
        tick();
        bus.start = 1'b0;
        for (int s = 1; s <= 8; s++) begin
            exp_key(s, 1'b1, 1'b0, "reload");
            if (s < 8) tick();
        end
        rst = 1'b1;
        #2;
        chk_idle("async reset", 1'b0);
        tick();
        chk_idle("reset held", 1'b0);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk_idle($sformatf("after abort %0d", j), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
